// File: rtl/int2fp_conv.sv
// ---------------------------------------------------------------------------
// int2fp_conv
//
// Sequential 32-bit integer (signed or unsigned) to IEEE-754 binary32
// converter. It feeds the floating-point divider's operand inputs, so it
// uses the same START/DONE handshake.
// Normalisation is a one-bit-per-cycle left-shift loop. Latency is lz+4
// edges for a non-zero operand (lz = leading zeros of the magnitude) and
// 2 edges for zero.
//
// Ports:
//   CLOCK      in   1  single clock, rising edge
//   RESET      in   1  asynchronous, active-low reset
//   START      in   1  request a conversion (sampled only in IDLE)
//   SIGNED     in   1  1 = InputInt is two's complement, 0 = unsigned
//   InputInt   in  32  integer operand, sampled with START
//   Result     out 32  converted float, held until the next completion
//   DONE       out  1  one-cycle pulse when Result becomes valid
//   BUSY       out  1  high whenever the FSM is not in IDLE
//   EXCEPTION  out  2  2'b00 exact, 2'b01 inexact; held like Result
//
// Configuration macro:
//   INT2FP_ROUND_NEAREST_EN  defined     -> round to nearest, ties to even
//                            not defined -> truncate (round toward zero)
// ---------------------------------------------------------------------------
module int2fp_conv (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        START,
    input  logic        SIGNED,
    input  logic [31:0] InputInt,
    output logic [31:0] Result,
    output logic        DONE,
    output logic        BUSY,
    output logic [1:0]  EXCEPTION
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        PACK  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] in_reg;
    logic        signed_reg;
    logic        sign;
    logic [31:0] mag;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        inexact;
    logic        zero_flag;
    logic [4:0]  count;

    logic        abs_sign;
    logic [31:0] abs_val;
    logic        norm_done;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_sum;

    // Magnitude of the captured operand. Negating 0x80000000 wraps back to
    // 0x80000000, which is exactly the unsigned magnitude we want.
    assign abs_sign = signed_reg & in_reg[31];
    assign abs_val  = abs_sign ? (~in_reg + 32'd1) : in_reg;

    // The counter is a safety bound only: a non-zero magnitude always has
    // its leading one in bit 31 after at most 31 shifts.
    assign norm_done = mag[31] | (count == 5'd31);

    // Bits below the 23-bit fraction decide rounding.
    assign guard  = mag[7];
    assign sticky = |mag[6:0];

`ifdef INT2FP_ROUND_NEAREST_EN
    // Ties go to the even fraction: mag[8] is the fraction LSB.
    assign round_up = guard & (sticky | mag[8]);
`else
    assign round_up = 1'b0;
`endif

    // Carry out of bit 23 means the fraction wrapped to zero and the
    // exponent must step up by one.
    assign frac_sum = {1'b0, mag[30:8]} + {23'd0, round_up};

    assign BUSY = (state != IDLE);

    // State register
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (START) state_next = ABS;
            ABS:     state_next = (abs_val == 32'd0) ? PACK : NORM;
            NORM:    if (norm_done) state_next = ROUND;
            ROUND:   state_next = PACK;
            PACK:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            in_reg     <= 32'd0;
            signed_reg <= 1'b0;
            sign       <= 1'b0;
            mag        <= 32'd0;
            exp        <= 8'd0;
            frac       <= 23'd0;
            inexact    <= 1'b0;
            zero_flag  <= 1'b0;
            count      <= 5'd0;
            Result     <= 32'd0;
            EXCEPTION  <= 2'b00;
            DONE       <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        in_reg     <= InputInt;
                        signed_reg <= SIGNED;
                    end
                end
                ABS: begin
                    sign      <= abs_sign;
                    mag       <= abs_val;
                    exp       <= 8'd158;
                    count     <= 5'd0;
                    inexact   <= 1'b0;
                    zero_flag <= (abs_val == 32'd0);
                end
                NORM: begin
                    if (!norm_done) begin
                        mag   <= {mag[30:0], 1'b0};
                        exp   <= exp - 8'd1;
                        count <= count + 5'd1;
                    end
                end
                ROUND: begin
                    frac    <= frac_sum[22:0];
                    inexact <= guard | sticky;
                    if (frac_sum[23]) begin
                        exp <= exp + 8'd1;
                    end
                end
                PACK: begin
                    Result    <= zero_flag ? 32'd0 : {sign, exp, frac};
                    EXCEPTION <= {1'b0, inexact};
                    DONE      <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
